// File: rtl/tpu_instr_issue_ctrl.sv
// tpu_instr_issue_ctrl
// Builds 80-bit TPU instructions from three 32-bit register-window writes,
// queues them in a small FIFO and hands them to the TPU with valid/ready.
// Word 0 is the control/status register. Words 1..3 form the staging register.
// A write to word 3 commits the staged instruction into the FIFO.
// synchronize pulses once when the queue has drained and the TPU has gone quiet.
module tpu_instr_issue_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int INSTR_WIDTH = 80
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [1:0]             wr_addr,
    input  logic [31:0]            wr_data,
    input  logic [3:0]             wr_strb,
    input  logic                   rd_en,
    input  logic [1:0]             rd_addr,
    output logic [31:0]            rd_data,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   tpu_busy,
    output logic                   synchronize
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    // Byte-enable merge of a 32-bit write into an existing word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    logic [INSTR_WIDTH-1:0] staging;
    logic [INSTR_WIDTH-1:0] stage_next;
    logic [INSTR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   overflow;
    logic [15:0]            issued;
    logic                   prev_idle;

    logic        empty;
    logic        full;
    logic        idle;
    logic        commit;
    logic        ctrl_wr;
    logic        flush;
    logic        pop;
    logic        push_ok;
    logic        overflow_set;
    logic [31:0] status;
    logic [31:0] hi_word;

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign idle        = empty && !tpu_busy;
    assign instr_valid = !empty;
    assign instr_out   = fifo_mem[rd_ptr];
    assign pop         = instr_valid && instr_ready;

    assign commit  = wr_en && (wr_addr == 2'd3);
    assign ctrl_wr = wr_en && (wr_addr == 2'd0) && wr_strb[0];
    assign flush   = ctrl_wr && wr_data[1];

    // A commit is lost only when the queue stays full; a flush discards it silently.
    assign push_ok      = commit && !flush && (!full || pop);
    assign overflow_set = commit && !flush && full && !pop;

    assign hi_word = {16'h0, staging[79:64]};
    assign status  = {issued, 8'(count), 4'h0, idle, overflow, full, empty};

    // Post-write staging value: the commit pushes this so that word-3 bytes land in the entry.
    always_comb begin
        stage_next = staging;
        if (wr_en) begin
            case (wr_addr)
                2'd1:    stage_next[31:0]  = merge_bytes(staging[31:0], wr_data, wr_strb);
                2'd2:    stage_next[63:32] = merge_bytes(staging[63:32], wr_data, wr_strb);
                2'd3:    stage_next[79:64] = 16'(merge_bytes(hi_word, wr_data, wr_strb & 4'b0011));
                default: stage_next = staging;
            endcase
        end
    end

    // Staging register holds its value across commits so it can be re-issued.
    always_ff @(posedge clk) begin
        if (reset) staging <= '0;
        else       staging <= stage_next;
    end

    // FIFO storage is pure data and carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= stage_next;
    end

    // FIFO pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset)                          overflow <= 1'b0;
        else if (overflow_set)              overflow <= 1'b1;
        else if (ctrl_wr && wr_data[0])     overflow <= 1'b0;
    end

    // Issued-instruction counter, wraps naturally at 16 bits; a pop during a flush still counts.
    always_ff @(posedge clk) begin
        if (reset)                      issued <= '0;
        else if (ctrl_wr && wr_data[2]) issued <= '0;
        else if (pop)                   issued <= issued + 16'd1;
    end

    // Registered read port; samples state before any same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            case (rd_addr)
                2'd0:    rd_data <= status;
                2'd1:    rd_data <= staging[31:0];
                2'd2:    rd_data <= staging[63:32];
                default: rd_data <= hi_word;
            endcase
        end
    end

    // One-cycle pulse on idle rising; prev_idle resets high so reset itself never pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_idle   <= 1'b1;
            synchronize <= 1'b0;
        end else begin
            prev_idle   <= idle;
            synchronize <= idle && !prev_idle;
        end
    end

endmodule

// File: tb/tb_tpu_instr_issue_ctrl.sv
// Directed bench for tpu_instr_issue_ctrl with hand-computed expectations.
module tb_tpu_instr_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic [79:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        tpu_busy;
    logic        synchronize;

    int checks = 0;
    int errors = 0;

    tpu_instr_issue_ctrl #(.FIFO_DEPTH(4), .INSTR_WIDTH(80)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .tpu_busy   (tpu_busy),
        .synchronize(synchronize)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    int pulses;
    logic first_seen;

    initial begin
        reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
        rd_en = 0; rd_addr = 0; instr_ready = 0; tpu_busy = 0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", 80'(instr_valid), 80'h0);
        chk("rst_sync", 80'(synchronize), 80'h0);
        chk("rst_rdata", 80'(rd_data), 80'h0);
        rd(2'd0);
        chk("rst_status", 80'(rd_data), 80'h9);

        // Basic build and commit
        wr(2'd1, 32'hAFFEDEAD, 4'hF);
        wr(2'd2, 32'hDEADAFFE, 4'hF);
        chk("pre_commit_valid", 80'(instr_valid), 80'h0);
        wr(2'd3, 32'h0000C0FE, 4'hF);
        chk("commit_valid", 80'(instr_valid), 80'h1);
        chk("commit_instr", instr_out, 80'hC0FE_DEADAFFE_AFFEDEAD);
        rd(2'd0);
        chk("commit_status", 80'(rd_data), 80'h0000_0100);
        rd(2'd3);
        chk("rd_word3", 80'(rd_data), 80'h0000_C0FE);
        chk("hold_instr", instr_out, 80'hC0FE_DEADAFFE_AFFEDEAD);

        // Flush, then overflow with five commits
        wr(2'd0, 32'h2, 4'h1);
        chk("flush_valid", 80'(instr_valid), 80'h0);
        for (int i = 0; i < 5; i++) begin
            wr(2'd1, 32'h100 + i, 4'hF);
            wr(2'd3, 32'h0, 4'hF);
        end
        rd(2'd0);
        chk("ovf_status", 80'(rd_data), 80'h0000_0406);
        wr(2'd0, 32'h1, 4'h1);
        rd(2'd0);
        chk("ovf_clr_status", 80'(rd_data), 80'h0000_0402);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 80'(instr_out[31:0]), 80'(32'h100 + i));
            tick();
        end
        instr_ready = 1'b0;
        chk("drain_sync0", 80'(synchronize), 80'h0);
        tick();
        chk("drain_sync1", 80'(synchronize), 80'h1);
        tick();
        chk("drain_sync2", 80'(synchronize), 80'h0);
        rd(2'd0);
        chk("drain_status", 80'(rd_data), 80'h0004_0009);

        // Commit into a full FIFO while popping
        for (int i = 0; i < 4; i++) begin
            wr(2'd1, 32'h200 + i, 4'hF);
            wr(2'd3, 32'h0, 4'hF);
        end
        wr(2'd1, 32'h204, 4'hF);
        instr_ready = 1'b1;
        wr(2'd3, 32'h0, 4'hF);
        instr_ready = 1'b0;
        rd(2'd0);
        chk("fullpop_status", 80'(rd_data), 80'h0005_0402);
        instr_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk("fullpop_order", 80'(instr_out[31:0]), 80'(32'h200 + i));
            tick();
        end
        instr_ready = 1'b0;
        chk("fullpop_empty", 80'(instr_valid), 80'h0);

        // Partial strobes on word 3
        wr(2'd3, 32'h0000_1234, 4'hF);
        wr(2'd3, 32'hFFFF_AB00, 4'b0010);
        rd(2'd3);
        chk("strb_word3", 80'(rd_data), 80'h0000_AB34);
        rd(2'd0);
        chk("strb_status", 80'(rd_data), 80'h0009_0200);
        instr_ready = 1'b1;
        chk("strb_entry0", 80'(instr_out[79:64]), 80'h1234);
        tick();
        chk("strb_entry1", 80'(instr_out[79:64]), 80'hAB34);
        tick();
        instr_ready = 1'b0;

        // Read and write to the same word in one cycle
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h55; wr_strb = 4'hF;
        rd_en = 1'b1; rd_addr = 2'd1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rw_prewrite", 80'(rd_data), 80'h204);
        tick();
        chk("rd_hold", 80'(rd_data), 80'h204);
        rd(2'd1);
        chk("rw_postwrite", 80'(rd_data), 80'h55);

        // Synchronize waits for tpu_busy
        tpu_busy = 1'b1;
        wr(2'd3, 32'h0, 4'hF);
        wr(2'd3, 32'h0, 4'hF);
        instr_ready = 1'b1;
        tick(); tick();
        instr_ready = 1'b0;
        chk("busy_empty", 80'(instr_valid), 80'h0);
        tick();
        chk("busy_nosync", 80'(synchronize), 80'h0);
        tpu_busy = 1'b0;
        pulses = 0;
        first_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (synchronize) pulses++;
            if (i == 0) first_seen = synchronize;
        end
        chk("busy_sync_first", 80'(first_seen), 80'h1);
        chk("busy_sync_count", 80'(pulses), 80'h1);

        // Flush with a concurrent pop, issued clear, then reset with work queued
        wr(2'd3, 32'h0, 4'hF);
        wr(2'd3, 32'h0, 4'hF);
        rd(2'd0);
        chk("pre_flush_status", 80'(rd_data), 80'h000D_0200);
        instr_ready = 1'b1;
        wr(2'd0, 32'h2, 4'h1);
        instr_ready = 1'b0;
        rd(2'd0);
        chk("flushpop_status", 80'(rd_data), 80'h000E_0009);
        wr(2'd0, 32'h4, 4'h1);
        rd(2'd0);
        chk("issued_clr", 80'(rd_data), 80'h0000_0009);
        for (int i = 0; i < 3; i++) wr(2'd3, 32'h0, 4'hF);
        chk("pre_rst_valid", 80'(instr_valid), 80'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 80'(instr_valid), 80'h0);
        chk("mid_rst_rdata", 80'(rd_data), 80'h0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (synchronize) pulses++;
            tick();
        end
        chk("mid_rst_nosync", 80'(pulses), 80'h0);
        rd(2'd0);
        chk("mid_rst_status", 80'(rd_data), 80'h9);
        rd(2'd3);
        chk("mid_rst_staging", 80'(rd_data), 80'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
